estufa_atuador_ctrl: RTL and testbench
======================================

// Module: estufa_atuador_ctrl
// PURPOSE
//  Downstream stage of the greenhouse (estufa) sensor decode: takes raw T1/T2 sensors,
//  decides heat/cool/fault and drives heater, cooler and red-LED actuators with timing.
//  Enforces minimum on-time, heater/cooler dead time and blinking fault indication.
//  Sits between SWI[7:6] and LED[6], LED[7], SEG[7] in top.
// PARAMETERS
//  MIN_ON      4  min cycles heater/cooler stays on once started (>=1)
//  DEAD        2  cycles both actuators forced off between any two active modes (>=1)
//  BLINK_HALF  2  cycles per half-period of red_led blink in FAULT (>=1)
//  CNT_W       8  width of internal cycle counter; must hold max(MIN_ON,DEAD,BLINK_HALF)
// PORTS
//  clk_2    in   1  system clock (divided clock from top)
//  reset    in   1  synchronous reset, active-high
//  t1       in   1  temperature sensor T1 (SWI[6])
//  t2       in   1  temperature sensor T2 (SWI[7])
//  heater   out  1  heater drive (LED[6])
//  cooler   out  1  cooler drive (LED[7])
//  red_led  out  1  fault indicator (SEG[7])
//  state_o  out  3  FSM state: IDLE=0 HEAT=1 COOL=2 DEAD=3 FAULT=4
// BEHAVIOUR
//  - Decode (combinational, on sampled t1/t2): heat_req=!t1&!t2; cool_req=t1&t2;
//    fault=!t1&t2; t1&!t2 = no request.
//  - Reset (sync, high): next edge -> IDLE, cnt=0; heater=cooler=red_led=0, state_o=0.
//    Reset overrides all events, incl. mid-HEAT/COOL/FAULT; no MIN_ON/DEAD honoured.
//  - All outputs decoded from registered state/blink flop only (Moore); latency 1 cycle
//    from the edge that samples a request to the output change. No combinational in->out.
//  - cnt clears on every state change; else increments, saturating at 2^CNT_W-1.
//  - Priority within every state: fault > own-mode hold > new request.
//  - IDLE: fault->FAULT; else heat_req->HEAT; else cool_req->COOL; else stay.
//  - HEAT (heater=1): fault->FAULT immediately (MIN_ON not honoured);
//    else if !heat_req && cnt>=MIN_ON-1 -> DEAD; else stay.
//    Heater high for max(MIN_ON, request length) cycles.
//  - COOL (cooler=1): symmetric to HEAT with cool_req.
//  - DEAD (both 0): fault->FAULT; else if cnt>=DEAD-1 -> IDLE (requests evaluated there).
//    Direct HEAT<->COOL transition never occurs; always >=DEAD off cycles between modes.
//  - FAULT (both 0): red_led=1 on entry, toggles every BLINK_HALF cycles while in FAULT.
//    Leave to DEAD on the first sampled cycle with !fault; red_led=0 from that edge.
//  - Outside FAULT red_led=0. heater&cooler never both 1 (invariant).
// CONFIGURATION
//  ESTUFA_SYNC_EN defined: t1/t2 pass a 2-flop synchronizer (flops reset to 0 -> decodes
//    as heat_req after reset until flushed); input-to-output latency becomes 3 cycles.
//  Undefined: t1/t2 used directly; latency 1 cycle. All FSM rules identical either way.
// TESTING  (MIN_ON=4, DEAD=2, BLINK_HALF=2, ESTUFA_SYNC_EN undefined)
//  1 reset=1 2 cycles, t1=1 t2=0 -> all outputs 0, state_o=0; stays IDLE after release.
//  2 t1=0 t2=0 for 1 cycle then t1=1 t2=0 -> heater=1 exactly 4 cycles, then 0 for
//    2 cycles (state_o=3), then state_o=0.
//  3 heat_req 10 cycles then immediately cool_req held -> heater=1 10 cycles,
//    2 cycles both 0, then cooler=1; heater never overlaps cooler.
//  4 in HEAT at cnt=1 apply t1=0 t2=1 -> next edge heater=0, state_o=4, red_led pattern
//    1,1,0,0,1,1..; clear fault -> red_led=0, DEAD 2 cycles, then IDLE.
//  5 reset=1 for 1 cycle mid-COOL (cnt=1) with cool_req held -> cooler=0 that edge,
//    IDLE, then COOL re-entered one cycle after reset drops (no DEAD).
//  6 define ESTUFA_SYNC_EN, repeat scenario 2 -> same waveform delayed by 2 cycles.

Source files
------------

// File: rtl/estufa_atuador_ctrl.sv
// Greenhouse actuator controller: decodes T1/T2 into heat/cool/fault and drives heater,
// cooler and a blinking red LED. Optional input synchronizer enabled by ESTUFA_SYNC_EN.
module estufa_atuador_ctrl #(
  parameter int MIN_ON     = 4,
  parameter int DEAD       = 2,
  parameter int BLINK_HALF = 2,
  parameter int CNT_W      = 8
) (
  input  logic       clk_2,
  input  logic       reset,
  input  logic       t1,
  input  logic       t2,
  output logic       heater,
  output logic       cooler,
  output logic       red_led,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HEAT  = 3'd1,
    S_COOL  = 3'd2,
    S_DEAD  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] L_MIN_LAST   = CNT_W'(MIN_ON - 1);
  localparam logic [CNT_W-1:0] L_DEAD_LAST  = CNT_W'(DEAD - 1);
  localparam logic [CNT_W-1:0] L_BLINK_LAST = CNT_W'(BLINK_HALF - 1);
  localparam logic [CNT_W-1:0] L_CNT_MAX    = {CNT_W{1'b1}};

  logic w_t1;
  logic w_t2;

`ifdef ESTUFA_SYNC_EN
  // Two-flop synchronizer; zeros after reset decode as a heat request until flushed.
  logic [1:0] r_sync1;
  logic [1:0] r_sync2;

  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
    end else begin
      r_sync1 <= {t2, t1};
      r_sync2 <= r_sync1;
    end
  end

  assign w_t1 = r_sync2[0];
  assign w_t2 = r_sync2[1];
`else
  assign w_t1 = t1;
  assign w_t2 = t2;
`endif

  logic w_heat_req;
  logic w_cool_req;
  logic w_fault;

  assign w_heat_req = ~w_t1 & ~w_t2;
  assign w_cool_req =  w_t1 &  w_t2;
  assign w_fault    = ~w_t1 &  w_t2;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_blink;
  logic [CNT_W-1:0] r_bcnt;

  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_cnt <= '0;
      end else if (r_cnt != L_CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Fault dominates every state; a mode holds while its own request persists.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_fault)         w_next = S_FAULT;
        else if (w_heat_req) w_next = S_HEAT;
        else if (w_cool_req) w_next = S_COOL;
      end
      S_HEAT: begin
        if (w_fault)                                w_next = S_FAULT;
        else if (!w_heat_req && r_cnt >= L_MIN_LAST) w_next = S_DEAD;
      end
      S_COOL: begin
        if (w_fault)                                w_next = S_FAULT;
        else if (!w_cool_req && r_cnt >= L_MIN_LAST) w_next = S_DEAD;
      end
      S_DEAD: begin
        if (w_fault)                    w_next = S_FAULT;
        else if (r_cnt >= L_DEAD_LAST)  w_next = S_IDLE;
      end
      S_FAULT: begin
        if (!w_fault) w_next = S_DEAD;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Blink flop starts high on FAULT entry and flips every BLINK_HALF cycles inside it.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_blink <= 1'b0;
      r_bcnt  <= '0;
    end else if (w_next == S_FAULT) begin
      if (r_state != S_FAULT) begin
        r_blink <= 1'b1;
        r_bcnt  <= '0;
      end else if (r_bcnt >= L_BLINK_LAST) begin
        r_blink <= ~r_blink;
        r_bcnt  <= '0;
      end else begin
        r_bcnt <= r_bcnt + 1'b1;
      end
    end else begin
      r_blink <= 1'b0;
      r_bcnt  <= '0;
    end
  end

  assign heater  = (r_state == S_HEAT);
  assign cooler  = (r_state == S_COOL);
  assign red_led = r_blink & (r_state == S_FAULT);
  assign state_o = r_state;

endmodule

// File: tb/tb_estufa_atuador_ctrl.sv
// Directed + random bench for estufa_atuador_ctrl with a cycle reference model and
// an expected-output queue compared one cycle after each driven input.
module tb_estufa_atuador_ctrl;

  localparam int MIN_ON     = 4;
  localparam int DEAD       = 2;
  localparam int BLINK_HALF = 2;
  localparam int CNT_W      = 8;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b1;
  logic       t1    = 1'b1;
  logic       t2    = 1'b0;
  logic       heater;
  logic       cooler;
  logic       red_led;
  logic [2:0] state_o;

  int total = 0;
  int bad   = 0;

  logic [5:0] exp_q[$];

  int         m_state = 0;
  int         m_cnt   = 0;
  int         m_bcnt  = 0;
  logic       m_blink = 1'b0;
  logic [1:0] m_p1    = 2'b00;
  logic [1:0] m_p2    = 2'b00;

  int         heat_cnt = 0;
  int         cool_cnt = 0;
  int         dead_cnt = 0;
  int         overlap  = 0;
  logic [5:0] red_bits = 6'b0;
  int         red_n    = 0;

  estufa_atuador_ctrl #(
    .MIN_ON(MIN_ON), .DEAD(DEAD), .BLINK_HALF(BLINK_HALF), .CNT_W(CNT_W)
  ) dut (
    .clk_2   (clk_2),
    .reset   (reset),
    .t1      (t1),
    .t2      (t2),
    .heater  (heater),
    .cooler  (cooler),
    .red_led (red_led),
    .state_o (state_o)
  );

  always #5 clk_2 = ~clk_2;

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: one clock of the controller, pushing the expected outputs.
  task automatic model_step(input logic r, input logic a, input logic b);
    logic ea, eb, hr, cr, f;
    int   nxt;
    ea = a;
    eb = b;
`ifdef ESTUFA_SYNC_EN
    ea   = m_p2[0];
    eb   = m_p2[1];
    m_p2 = r ? 2'b00 : m_p1;
    m_p1 = r ? 2'b00 : {b, a};
`endif
    if (r) begin
      m_state = 0;
      m_cnt   = 0;
      m_blink = 1'b0;
      m_bcnt  = 0;
    end else begin
      hr  = !ea && !eb;
      cr  = ea && eb;
      f   = !ea && eb;
      nxt = m_state;
      case (m_state)
        0: nxt = f ? 4 : hr ? 1 : cr ? 2 : 0;
        1: nxt = f ? 4 : (!hr && m_cnt >= MIN_ON - 1) ? 3 : 1;
        2: nxt = f ? 4 : (!cr && m_cnt >= MIN_ON - 1) ? 3 : 2;
        3: nxt = f ? 4 : (m_cnt >= DEAD - 1) ? 0 : 3;
        default: nxt = f ? 4 : 3;
      endcase
      if (nxt == 4) begin
        if (m_state != 4) begin
          m_blink = 1'b1;
          m_bcnt  = 0;
        end else if (m_bcnt == BLINK_HALF - 1) begin
          m_blink = !m_blink;
          m_bcnt  = 0;
        end else begin
          m_bcnt++;
        end
      end else begin
        m_blink = 1'b0;
        m_bcnt  = 0;
      end
      if (nxt != m_state) m_cnt = 0;
      else if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
      m_state = nxt;
    end
    exp_q.push_back({3'(m_state), m_state == 1, m_state == 2, m_blink});
  endtask

  task automatic cyc(input logic r, input logic a, input logic b, input string tag);
    logic [5:0] obs, exp;
    reset = r;
    t1    = a;
    t2    = b;
    model_step(r, a, b);
    @(posedge clk_2);
    #1;
    obs = {state_o, heater, cooler, red_led};
    exp = exp_q.pop_front();
    check(tag, obs, exp);
    if (heater && cooler) overlap++;
    if (heater) heat_cnt++;
    if (cooler) cool_cnt++;
    if (state_o == 3'd3) dead_cnt++;
    if (state_o == 3'd4) begin
      red_bits = {red_bits[4:0], red_led};
      red_n++;
    end
  endtask

  task automatic clr_stats();
    heat_cnt = 0;
    cool_cnt = 0;
    dead_cnt = 0;
    red_bits = 6'b0;
    red_n    = 0;
  endtask

  initial begin
    // 1: reset held with no request, then released
    cyc(1'b1, 1'b1, 1'b0, "s1_reset");
    cyc(1'b1, 1'b1, 1'b0, "s1_reset");
    check("s1_reset_outputs", {state_o, heater, cooler, red_led}, 6'd0);
    repeat (3) cyc(1'b0, 1'b1, 1'b0, "s1_idle");
    check("s1_stays_idle", {3'b0, state_o}, 6'd0);

    // 2: single-cycle heat request honours MIN_ON then DEAD
    clr_stats();
    cyc(1'b0, 1'b0, 1'b0, "s2_heat");
    repeat (10) cyc(1'b0, 1'b1, 1'b0, "s2_release");
    check("s2_heat_cycles", 6'(heat_cnt), 6'd4);
    check("s2_dead_cycles", 6'(dead_cnt), 6'd2);
    check("s2_back_idle", {3'b0, state_o}, 6'd0);

    // 3: long heat then cool, never overlapping
    clr_stats();
    repeat (10) cyc(1'b0, 1'b0, 1'b0, "s3_heat");
    repeat (8) cyc(1'b0, 1'b1, 1'b1, "s3_cool");
    check("s3_heat_cycles", 6'(heat_cnt), 6'd10);
    check("s3_cool_seen", 6'(cool_cnt > 0), 6'd1);
    repeat (8) cyc(1'b0, 1'b1, 1'b0, "s3_release");
    check("s3_back_idle", {3'b0, state_o}, 6'd0);

    // 4: fault interrupts HEAT at cnt=1, blinks, then clears through DEAD
    clr_stats();
    cyc(1'b0, 1'b0, 1'b0, "s4_heat");
    cyc(1'b0, 1'b0, 1'b0, "s4_heat");
    repeat (6) cyc(1'b0, 1'b0, 1'b1, "s4_fault");
    check("s4_red_pattern", red_bits, 6'b110011);
    check("s4_fault_cycles", 6'(red_n), 6'd6);
    cyc(1'b0, 1'b1, 1'b0, "s4_clear");
    check("s4_clear_dead", {state_o, heater, cooler, red_led}, {3'd3, 3'b000});
    repeat (3) cyc(1'b0, 1'b1, 1'b0, "s4_recover");
    check("s4_back_idle", {3'b0, state_o}, 6'd0);

    // 5: reset mid-COOL, COOL re-entered without DEAD
    cyc(1'b0, 1'b1, 1'b1, "s5_cool");
    cyc(1'b0, 1'b1, 1'b1, "s5_cool");
    cyc(1'b1, 1'b1, 1'b1, "s5_reset");
    check("s5_reset_idle", {state_o, heater, cooler, red_led}, 6'd0);
    cyc(1'b0, 1'b1, 1'b1, "s5_reenter");
    check("s5_cool_again", {state_o, heater, cooler, red_led}, {3'd2, 3'b010});
    repeat (6) cyc(1'b0, 1'b1, 1'b0, "s5_release");

    // Random inputs with sparse resets against the model
    for (int i = 0; i < 200; i++) begin
      cyc($urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), "rand");
    end
    check("no_overlap", 6'(overlap), 6'd0);
    check("queue_drained", 6'(exp_q.size()), 6'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
